// File: rtl/mem_window_out.sv
// Turns one banked SRAM read per cycle into an NROW x NCOL sliding pixel window
// with left/right edge replication. Define MEM_WINDOW_OUT_CE_CHECK_EN for the sticky err_ce check.
module mem_window_out #(
  parameter int DW      = 8,
  parameter int NBANK   = 8,
  parameter int NROW    = 7,
  parameter int NCOL    = 3,
  parameter int TAIL    = 1,
  parameter int PAD_VAL = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk_oe,
  input  logic [NBANK-1:0]         blk_ce,
  input  logic [NBANK*DW-1:0]      blk_rdata,
  input  logic [NROW-1:0]          pad_en,
  output logic                     win_vld,
  output logic [NROW*NCOL*DW-1:0]  win_data,
  output logic                     win_first,
  output logic                     win_last,
  output logic [11:0]              col_cnt,
  output logic                     err_ce
);

  localparam int              CW     = NROW * DW;
  localparam int              KW     = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [3:0]      TAIL_L = 4'(TAIL);
  localparam logic [DW-1:0]   PAD_L  = DW'(PAD_VAL);

  typedef enum logic [1:0] {IDLE, INIT, ACTIVE, POST} state_t;

  state_t           state;
  state_t           ns;
  state_t           nns;
  logic             oe_d;
  logic [NBANK-1:0] ce_d;
  logic [3:0]       tcnt;
  logic [3:0]       tcnt_nx;
  logic             ce_ok;
  logic [KW-1:0]    k;
  logic [CW-1:0]    col_new;
  logic [CW-1:0]    col_q [NCOL];

  // The register "state" names the action taken on the previous edge; tc counts POST actions so far.
  function automatic state_t next_of(input state_t s, input logic oe, input logic [3:0] tc);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:         n = oe ? INIT : IDLE;
      INIT, ACTIVE: n = oe ? ACTIVE : ((TAIL == 0) ? IDLE : POST);
      POST:         n = oe ? INIT : ((tc >= TAIL_L) ? IDLE : POST);
      default:      n = IDLE;
    endcase
    return n;
  endfunction

  assign ce_ok = $onehot(~ce_d);

  always_comb begin
    k = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (!ce_d[b]) k = KW'(b);
    end
    if (!ce_ok) k = '0;
  end

  always_comb begin
    int bank;
    bank    = 0;
    col_new = '0;
    for (int r = 0; r < NROW; r++) begin
      bank = (int'(k) + r) % NBANK;
      col_new[r*DW +: DW] = pad_en[r] ? PAD_L : blk_rdata[bank*DW +: DW];
    end
  end

  // nns looks one step further using blk_oe (tomorrow's oe_d) so win_last lands on the window itself.
  always_comb begin
    ns      = next_of(state, oe_d, tcnt);
    tcnt_nx = '0;
    if (ns == POST) tcnt_nx = (state == POST) ? tcnt + 4'd1 : 4'd1;
    nns     = next_of(ns, blk_oe, tcnt_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      oe_d      <= 1'b0;
      ce_d      <= '0;
      tcnt      <= '0;
      col_cnt   <= '0;
      win_vld   <= 1'b0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      for (int c = 0; c < NCOL; c++) col_q[c] <= '0;
    end else begin
      oe_d      <= blk_oe;
      ce_d      <= blk_ce;
      state     <= ns;
      tcnt      <= tcnt_nx;
      win_vld   <= (ns != IDLE);
      win_first <= (ns == INIT);
      win_last  <= (ns != IDLE) && ((nns == IDLE) || (nns == INIT));
      case (ns)
        INIT: begin
          for (int c = 0; c < NCOL; c++) col_q[c] <= col_new;
        end
        ACTIVE: begin
          col_q[0] <= col_new;
          for (int c = 1; c < NCOL; c++) col_q[c] <= col_q[c-1];
        end
        POST: begin
          for (int c = 1; c < NCOL; c++) col_q[c] <= col_q[c-1];
        end
        default: ;
      endcase
      if (ns == INIT)
        col_cnt <= '0;
      else if ((ns != IDLE) && (col_cnt != 12'hFFF))
        col_cnt <= col_cnt + 12'd1;
    end
  end

  always_comb begin
    win_data = '0;
    if (win_vld) begin
      for (int c = 0; c < NCOL; c++) win_data[c*CW +: CW] = col_q[c];
    end
  end

`ifdef MEM_WINDOW_OUT_CE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_ce <= 1'b0;
    else if (oe_d && !ce_ok)
      err_ce <= 1'b1;
  end
`else
  assign err_ce = 1'b0;
`endif

endmodule

// File: tb/tb_mem_window_out.sv
// Directed bench for mem_window_out: table of single lines plus hand sequences for
// err_ce, mid-line reset, tail truncation (TAIL=2 instance) and col_cnt saturation.
module tb_mem_window_out;

  localparam int DW    = 8;
  localparam int NBANK = 8;
  localparam int NROW  = 7;
  localparam int NCOL  = 3;
  localparam int WW    = NROW * NCOL * DW;
`ifdef MEM_WINDOW_OUT_CE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                blk_oe = 1'b0;
  logic [NBANK-1:0]    blk_ce = '1;
  logic [NBANK*DW-1:0] blk_rdata = '0;
  logic [NROW-1:0]     pad_en = '0;

  logic          win_vld, win_first, win_last, err_ce;
  logic [WW-1:0] win_data;
  logic [11:0]   col_cnt;
  logic          win_vld2, win_first2, win_last2, err_ce2;
  logic [WW-1:0] win_data2;
  logic [11:0]   col_cnt2;

  mem_window_out u_dut (
    .clk(clk), .rst(rst), .blk_oe(blk_oe), .blk_ce(blk_ce), .blk_rdata(blk_rdata),
    .pad_en(pad_en), .win_vld(win_vld), .win_data(win_data), .win_first(win_first),
    .win_last(win_last), .col_cnt(col_cnt), .err_ce(err_ce)
  );

  mem_window_out #(.TAIL(2)) u_dut2 (
    .clk(clk), .rst(rst), .blk_oe(blk_oe), .blk_ce(blk_ce), .blk_rdata(blk_rdata),
    .pad_en(pad_en), .win_vld(win_vld2), .win_data(win_data2), .win_first(win_first2),
    .win_last(win_last2), .col_cnt(col_cnt2), .err_ce(err_ce2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic          first;
    logic          last;
    logic [11:0]   cnt;
    int            cyc;
  } win_t;

  typedef struct {
    int         n;
    logic [7:0] ce;
    logic [6:0] pad;
    int         k;
    int         nwin;
    logic [7:0] r0;
    logic [7:0] r6;
  } vec_t;

  win_t       q1[$];
  win_t       q2[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         startCyc = 0;
  logic       prevOe = 1'b0;
  int         prevJ = 0;
  logic [6:0] prevPad = '0;

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bank b returns 16*b + j for the read issued at line offset j, one cycle after the issue.
  task automatic applyStimulus(input logic oe, input logic [7:0] ce, input logic [6:0] pad, input int j);
    @(posedge clk);
    #1;
    for (int b = 0; b < NBANK; b++)
      blk_rdata[b*DW +: DW] = prevOe ? 8'(16*b + prevJ) : 8'hEE;
    pad_en  = prevPad;
    blk_oe  = oe;
    blk_ce  = ce;
    prevOe  = oe;
    prevJ   = j;
    prevPad = pad;
  endtask

  // Window w, column c holds line column w-c clamped to [0, n-1] (edge replication).
  function automatic logic [WW-1:0] expWin(input int w, input int n, input int k, input logic [6:0] pad);
    logic [WW-1:0] res;
    int idx;
    res = '0;
    for (int c = 0; c < NCOL; c++) begin
      idx = w - c;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      for (int r = 0; r < NROW; r++)
        res[(c*NROW + r)*DW +: DW] = pad[r] ? 8'd128 : 8'(16*((k + r) % NBANK) + idx);
    end
    return res;
  endfunction

  task automatic runLine(input int n, input logic [7:0] ce, input logic [6:0] pad, input int idle);
    for (int j = 0; j < n; j++) begin
      applyStimulus(1'b1, ce, pad, j);
      if (j == 0) startCyc = cyc + 1;
    end
    for (int i = 0; i < idle; i++) applyStimulus(1'b0, 8'hFF, 7'h00, 0);
  endtask

  task automatic checkLine(input string tag, input int n, input int k, input logic [6:0] pad,
                           input int nwin, input logic [7:0] r0, input logic [7:0] r6);
    int expCnt;
    checkOutput($sformatf("%s_nwin", tag), WW'(q1.size()), WW'(nwin));
    if (q1.size() == nwin) begin
      checkOutput($sformatf("%s_latency", tag), WW'(q1[0].cyc), WW'(startCyc + 2));
      checkOutput($sformatf("%s_w0_row0", tag), WW'(q1[0].data[0 +: DW]), WW'(r0));
      checkOutput($sformatf("%s_w0_row6", tag), WW'(q1[0].data[6*DW +: DW]), WW'(r6));
      for (int w = 0; w < nwin; w++) begin
        expCnt = (w > 4095) ? 4095 : w;
        checkOutput($sformatf("%s_first_w%0d", tag, w), WW'(q1[w].first), WW'(w == 0));
        checkOutput($sformatf("%s_last_w%0d", tag, w), WW'(q1[w].last), WW'(w == nwin - 1));
        checkOutput($sformatf("%s_cnt_w%0d", tag, w), WW'(q1[w].cnt), WW'(expCnt));
        checkOutput($sformatf("%s_cyc_w%0d", tag, w), WW'(q1[w].cyc), WW'(q1[0].cyc + w));
        checkOutput($sformatf("%s_data_w%0d", tag, w), q1[w].data, expWin(w, n, k, pad));
      end
    end
    q1.delete();
    q2.delete();
  endtask

  always @(negedge clk) begin
    win_t w;
    cyc++;
    if (win_vld) begin
      w.data = win_data; w.first = win_first; w.last = win_last; w.cnt = col_cnt; w.cyc = cyc;
      q1.push_back(w);
    end else begin
      checkOutput("idle_data_zero", win_data, '0);
    end
    if (win_vld2) begin
      w.data = win_data2; w.first = win_first2; w.last = win_last2; w.cnt = col_cnt2; w.cyc = cyc;
      q2.push_back(w);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [6:0] expFirst;
    logic [6:0] expLast;
    int lastCount;
    int expCnt2[7];

    vecs[0] = '{4, 8'hFE, 7'b0000000, 0, 5, 8'd0,   8'd96};
    vecs[1] = '{4, 8'hBF, 7'b0000000, 6, 5, 8'd96,  8'd64};
    vecs[2] = '{3, 8'hFE, 7'b1000001, 0, 4, 8'd128, 8'd128};
    vecs[3] = '{1, 8'hFE, 7'b0000000, 0, 2, 8'd0,   8'd96};
    vecs[4] = '{5, 8'h7F, 7'b0000000, 7, 6, 8'd112, 8'd80};
    vecs[5] = '{2, 8'hFB, 7'b0000010, 2, 3, 8'd32,  8'd0};

    // Reset state
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    @(negedge clk);
    checkOutput("rst_vld", WW'(win_vld), '0);
    checkOutput("rst_first", WW'(win_first), '0);
    checkOutput("rst_last", WW'(win_last), '0);
    checkOutput("rst_cnt", WW'(col_cnt), '0);
    checkOutput("rst_err", WW'(err_ce), '0);
    checkOutput("rst_data", win_data, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    q1.delete();
    q2.delete();

    for (int v = 0; v < 6; v++) begin
      runLine(vecs[v].n, vecs[v].ce, vecs[v].pad, 6);
      checkLine($sformatf("vec%0d", v), vecs[v].n, vecs[v].k, vecs[v].pad,
                vecs[v].nwin, vecs[v].r0, vecs[v].r6);
    end
    checkOutput("err_before", WW'(err_ce), '0);

    // Non-one-hot enable: err_ce two cycles after the issue, sticky afterwards
    applyStimulus(1'b1, 8'hFC, 7'h00, 0);
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    @(negedge clk);
    checkOutput("err_t1", WW'(err_ce), '0);
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    @(negedge clk);
    checkOutput("err_t2", WW'(err_ce), WW'(ERR_EXP));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    checkOutput("err_sticky", WW'(err_ce), WW'(ERR_EXP));
    checkOutput("bad_ce_nwin", WW'(q1.size()), WW'(2));
    if (q1.size() == 2)
      checkOutput("bad_ce_k0", q1[0].data, expWin(0, 1, 0, 7'h00));
    q1.delete();
    q2.delete();

    // Mid-line reset abandons the line without win_last
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'hFE, 7'h00, j);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_vld", WW'(win_vld), '0);
    checkOutput("midrst_data", win_data, '0);
    checkOutput("midrst_first", WW'(win_first), '0);
    checkOutput("midrst_last", WW'(win_last), '0);
    checkOutput("midrst_cnt", WW'(col_cnt), '0);
    checkOutput("midrst_err", WW'(err_ce), '0);
    blk_oe = 1'b0;
    lastCount = 0;
    foreach (q1[i]) if (q1[i].last) lastCount++;
    checkOutput("midrst_no_last", WW'(lastCount), '0);
    checkOutput("midrst_nwin", WW'(q1.size()), WW'(1));
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    rst = 1'b0;
    q1.delete();
    q2.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    checkOutput("postrst_quiet", WW'(q1.size()), '0);
    runLine(2, 8'hFE, 7'h00, 6);
    checkLine("postrst", 2, 0, 7'h00, 3, 8'd0, 8'd96);

    // Back-to-back lines with a one-cycle gap: TAIL=2 tail is truncated, no window gap
    applyStimulus(1'b1, 8'hFE, 7'h00, 0);
    applyStimulus(1'b1, 8'hFE, 7'h00, 1);
    applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    applyStimulus(1'b1, 8'hFE, 7'h00, 0);
    applyStimulus(1'b1, 8'hFE, 7'h00, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'hFF, 7'h00, 0);
    expFirst = 7'b0001001;
    expLast  = 7'b1000100;
    expCnt2  = '{0, 1, 2, 0, 1, 2, 3};
    checkOutput("trunc_nwin", WW'(q2.size()), WW'(7));
    if (q2.size() == 7) begin
      for (int w = 0; w < 7; w++) begin
        checkOutput($sformatf("trunc_first_w%0d", w), WW'(q2[w].first), WW'(expFirst[w]));
        checkOutput($sformatf("trunc_last_w%0d", w), WW'(q2[w].last), WW'(expLast[w]));
        checkOutput($sformatf("trunc_cnt_w%0d", w), WW'(q2[w].cnt), WW'(expCnt2[w]));
        checkOutput($sformatf("trunc_cyc_w%0d", w), WW'(q2[w].cyc), WW'(q2[0].cyc + w));
        checkOutput($sformatf("trunc_data_w%0d", w), q2[w].data,
                    (w < 3) ? expWin(w, 2, 0, 7'h00) : expWin(w - 3, 2, 0, 7'h00));
      end
    end
    checkOutput("t1_nwin", WW'(q1.size()), WW'(6));
    if (q1.size() == 6) begin
      checkOutput("t1_last_w2", WW'(q1[2].last), WW'(1));
      checkOutput("t1_first_w3", WW'(q1[3].first), WW'(1));
      checkOutput("t1_last_w5", WW'(q1[5].last), WW'(1));
      checkOutput("t1_gap", WW'(q1[3].cyc), WW'(q1[2].cyc + 1));
    end
    q1.delete();
    q2.delete();

    // Long line: col_cnt saturates at 4095
    runLine(4100, 8'hFE, 7'h00, 6);
    checkLine("sat", 4100, 0, 7'h00, 4101, 8'd0, 8'd96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
